// File: rtl/fft3_cmul_pkg.sv
// Shared constants and phase encoding for the fft_3 complex-product combiner.
package fft3_cmul_pkg;
    localparam int PROD_W = 16;
    localparam int TERM_W = PROD_W + 1;
    localparam int SUM_W  = 18;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_t;
endpackage

// File: rtl/cmul_fifo_3.sv
// DEPTH x W synchronous FIFO; a push into a full FIFO is accepted only if a pop
// happens in the same cycle.
module cmul_fifo_3 #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/cmul_combine_3.sv
// Groups four signed products into re = s0 - s1, im = s2 + s3 and queues them.
// Define CMPLX_SAT_EN to saturate re/im to OUT_W bits instead of wrapping.
module cmul_combine_3
    import fft3_cmul_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PROD_W-1:0]       prod,
    input  logic                    prod_rdy,
    input  logic                    prod_neg,
    input  logic                    flush,
    input  logic                    clr_ovf,
    output logic signed [OUT_W-1:0] re,
    output logic signed [OUT_W-1:0] im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              phase,
    output logic                    ovf
);
`ifdef CMPLX_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - 1'sb1;
`endif

    function automatic logic [OUT_W-1:0] narrow(input logic signed [SUM_W-1:0] x);
`ifdef CMPLX_SAT_EN
        if (OUT_W < SUM_W && x > SAT_MAX) return OUT_W'(SAT_MAX);
        if (OUT_W < SUM_W && x < SAT_MIN) return OUT_W'(SAT_MIN);
`endif
        return OUT_W'(x);
    endfunction

    phase_t                    state_q, state_d;
    logic signed [TERM_W-1:0]  term;
    logic signed [TERM_W-1:0]  s0, s1, s2;
    logic signed [SUM_W-1:0]   re_sum, im_sum;
    logic                      complete;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic [2*OUT_W-1:0]        head;

    assign term   = prod_neg ? -$signed({1'b0, prod}) : $signed({1'b0, prod});
    assign re_sum = SUM_W'(s0) - SUM_W'(s1);
    assign im_sum = SUM_W'(s2) + SUM_W'(term);

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        if (flush) begin
            state_d = P0;
        end else if (prod_rdy) begin
            unique case (state_q)
                P0: state_d = P1;
                P1: state_d = P2;
                P2: state_d = P3;
                P3: begin
                    state_d  = P0;
                    complete = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= P0;
            s0      <= '0;
            s1      <= '0;
            s2      <= '0;
        end else begin
            state_q <= state_d;
            if (prod_rdy && !flush) begin
                unique case (state_q)
                    P0: s0 <= term;
                    P1: s1 <= term;
                    P2: s2 <= term;
                    P3: ;
                endcase
            end
        end
    end

    // A completing group is lost only when the FIFO is full and nothing drains this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       ovf <= 1'b0;
        else if (complete && full && !pop) ovf <= 1'b1;
        else if (clr_ovf)                 ovf <= 1'b0;
    end

    assign pop       = out_valid && out_ready;
    assign out_valid = !empty;
    assign phase     = state_q;
    assign re        = head[2*OUT_W-1:OUT_W];
    assign im        = head[OUT_W-1:0];

    cmul_fifo_3 #(
        .W     (2 * OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (complete),
        .pop     (pop),
        .wr_data ({narrow(re_sum), narrow(im_sum)}),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );
endmodule

// File: tb/tb_cmul_combine_3.sv
// Scoreboard bench for cmul_combine_3 (OUT_W=16, DEPTH=2).
module tb_cmul_combine_3;
    localparam int OUT_W = 16;
    localparam int DEPTH = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [15:0]             prod;
    logic                    prod_rdy;
    logic                    prod_neg;
    logic                    flush;
    logic                    clr_ovf;
    logic signed [OUT_W-1:0] re;
    logic signed [OUT_W-1:0] im;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              phase;
    logic                    ovf;

    cmul_combine_3 #(
        .OUT_W (OUT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prod      (prod),
        .prod_rdy  (prod_rdy),
        .prod_neg  (prod_neg),
        .flush     (flush),
        .clr_ovf   (clr_ovf),
        .re        (re),
        .im        (im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .phase     (phase),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int re;
        int im;
    } res_t;

    res_t q[$];
    int   ms[3];
    int   m_phase;
    bit   m_ovf;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int narrow(input int x);
`ifdef CMPLX_SAT_EN
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
`else
        logic [15:0] t;
        t = x[15:0];
        return int'($signed(t));
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_phase = 0;
        m_ovf   = 1'b0;
        ms      = '{0, 0, 0};
    endtask

    // One clock: check outputs mid-cycle, advance the model, then cross the edge.
    task automatic step();
        bit pop;
        bit set_ovf;
        int t;
        @(negedge clk);
        check("out_valid", int'(out_valid), int'(q.size() != 0));
        check("phase", int'(phase), m_phase);
        check("ovf", int'(ovf), int'(m_ovf));
        if (q.size() != 0) begin
            check("re", int'(re), q[0].re);
            check("im", int'(im), q[0].im);
        end
        pop     = (q.size() != 0) && out_ready;
        set_ovf = 1'b0;
        if (pop) void'(q.pop_front());
        if (flush) begin
            m_phase = 0;
        end else if (prod_rdy) begin
            t = prod_neg ? -int'(prod) : int'(prod);
            if (m_phase == 3) begin
                m_phase = 0;
                if (q.size() < DEPTH) q.push_back('{narrow(ms[0] - ms[1]), narrow(ms[2] + t)});
                else set_ovf = 1'b1;
            end else begin
                ms[m_phase] = t;
                m_phase++;
            end
        end
        if (set_ovf) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p, input bit n);
        prod     = 16'(p);
        prod_neg = n;
        prod_rdy = 1'b1;
        step();
        prod_rdy = 1'b0;
        prod_neg = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; prod = '0; prod_rdy = 1'b0; prod_neg = 1'b0;
        flush = 1'b0; clr_ovf = 1'b0; out_ready = 1'b1;
        model_reset();
        #12;
        check("rst_re", int'(re), 0);
        check("rst_im", int'(im), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic group: re=50, im=50
        send(100, 0); send(50, 0); send(30, 0); send(20, 0);
        idle(3);

        // Signed terms, including a negative zero
        send(200, 1); send(100, 0); send(7, 1); send(3, 1);
        send(0, 1); send(0, 0); send(5, 0); send(0, 1);
        idle(4);

        // Back-pressure: third group dropped
        out_ready = 1'b0;
        for (int g = 0; g < 3; g++) begin
            send(10 + g, 0); send(g, 1); send(3 * g, 0); send(g + 1, 1);
        end
        idle(3);
        out_ready = 1'b1;
        idle(3);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        idle(2);

        // Full FIFO with push and pop in the same cycle
        out_ready = 1'b0;
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        send(5, 1); send(6, 0); send(7, 0); send(8, 1);
        send(9, 0); send(10, 1); send(11, 0);
        out_ready = 1'b1;
        send(12, 0);
        idle(4);

        // Flush mid-group, then a clean group
        out_ready = 1'b0;
        send(1000, 0); send(900, 1);
        flush = 1'b1;
        send(800, 0);
        flush = 1'b0;
        send(40, 0); send(30, 1); send(20, 0); send(10, 0);
        idle(2);
        out_ready = 1'b1;
        idle(3);

        // Range extremes: re = im = 130050 internally
        send(65025, 0); send(65025, 1); send(65025, 0); send(65025, 0);
        send(65025, 1); send(65025, 0); send(65025, 1); send(65025, 1);
        idle(4);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            prod_rdy  = ($urandom_range(0, 3) != 0);
            prod      = 16'($urandom);
            prod_neg  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            clr_ovf   = ($urandom_range(0, 7) == 0);
            step();
        end
        prod_rdy = 1'b0; flush = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
        idle(1);

        // Async reset mid-group with data queued
        send(300, 0); send(200, 0); send(100, 0); send(50, 0);
        send(7, 0); send(9, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_re", int'(re), 0);
        check("arst_im", int'(im), 0);
        check("arst_valid", int'(out_valid), 0);
        check("arst_phase", int'(phase), 0);
        check("arst_ovf", int'(ovf), 0);
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(100, 0); send(50, 0); send(30, 0); send(20, 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
